// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth sequencer.
// States, Booth-pair decode and counter sizing.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } booth_state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_decode(
    input logic q0,
    input logic qm1
  );
    booth_op_t op;
    unique case (1'b1)
      (!q0 && qm1): op = ADD;
      (q0 && !qm1): op = SUB;
      default:      op = NOP;
    endcase
    return op;
  endfunction

  function automatic int CeilLog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_sequencer_counter.sv
// Iteration counter with synchronous clear and terminal flag.
// Flag is high while the count sits at MAXIMUM_VALUE-1.
module booth_iteration_counter
  import booth_pkg::*;
#(
  parameter int MAXIMUM_VALUE     = 16,
  parameter int NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE)
) (
  input  logic clk,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [NBITS_FOR_COUNTER-1:0] LAST =
    NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);
  localparam logic [NBITS_FOR_COUNTER-1:0] ONE =
    NBITS_FOR_COUNTER'(1);

  logic [NBITS_FOR_COUNTER-1:0] count_q, count_d;

  assign tc_o = (count_q == LAST);

  // Next count: clear wins, then step with wrap at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/booth_sequencer.sv
// Iterative radix-2 Booth signed multiplier.
// One Booth step per clock; product held until acknowledged.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WORD_LENGTH       = 16,
  parameter int NBITS_FOR_COUNTER = CeilLog2(WORD_LENGTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic [WORD_LENGTH-1:0]   multiplier,
  input  logic                     ack,
  output logic                     busy,
  output logic                     ready,
  output logic [2*WORD_LENGTH-1:0] product
);

  localparam int W = WORD_LENGTH;

  booth_state_t state_q, state_d;

  logic [W:0]     a_q, a_d;
  logic [W:0]     m_q, m_d;
  logic [W-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [2*W-1:0] prod_q, prod_d;

  logic           accept;
  logic           last;
  booth_op_t      op;
  logic [W:0]     sum;
  logic [2*W+1:0] shifted;
  logic [W:0]     a_n;
  logic [W-1:0]   q_n;

  assign busy    = (state_q == ITERATE);
  assign ready   = (state_q == DONE);
  assign product = prod_q;
  assign accept  = (state_q == IDLE) && start;

  booth_iteration_counter #(
    .MAXIMUM_VALUE     (W),
    .NBITS_FOR_COUNTER (NBITS_FOR_COUNTER)
  ) u_counter (
    .clk     (clk),
    .clear_i (accept || reset),
    .en_i    (busy),
    .tc_o    (last)
  );

  // Booth step: add/sub on the W+1 accumulator, then arithmetic shift.
  always_comb begin
    op = booth_decode(q_q[0], qm1_q);
    sum = a_q;
    unique case (op)
      ADD:     sum = a_q + m_q;
      SUB:     sum = a_q - m_q;
      default: sum = a_q;
    endcase
    shifted = {sum[W], sum, q_q};
    a_n     = shifted[2*W+1:W+1];
    q_n     = shifted[W:1];
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ITERATE;
      ITERATE: if (last)  state_d = DONE;
      DONE:    if (ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, step while iterating.
  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    prod_d = prod_q;
    if (accept) begin
      a_d   = '0;
      m_d   = {multiplicand[W-1], multiplicand};
      q_d   = multiplier;
      qm1_d = 1'b0;
    end else if (busy) begin
      a_d   = a_n;
      q_d   = q_n;
      qm1_d = shifted[0];
      if (last) prod_d = {a_n[W-1:0], q_n};
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer at WORD_LENGTH 16 and 8.
// Products are compared with plain signed multiplication.
module tb_booth_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start16, ack16, busy16, ready16;
  logic [15:0] m16, q16;
  logic [31:0] p16;
  logic        start8, ack8, busy8, ready8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  booth_sequencer #(.WORD_LENGTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .multiplicand (m16),
    .multiplier   (q16),
    .ack          (ack16),
    .busy         (busy16),
    .ready        (ready16),
    .product      (p16)
  );

  booth_sequencer #(.WORD_LENGTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start8),
    .multiplicand (m8),
    .multiplier   (q8),
    .ack          (ack8),
    .busy         (busy8),
    .ready        (ready8),
    .product      (p8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] m,
                                        input logic [15:0] q);
    logic signed [31:0] a, b;
    a = 32'(signed'(m));
    b = 32'(signed'(q));
    return a * b;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] m,
                                       input logic [7:0] q);
    logic signed [15:0] a, b;
    a = 16'(signed'(m));
    b = 16'(signed'(q));
    return a * b;
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] c [5];
    c = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return c[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] c [5];
    c = '{8'h80, 8'h7F, 8'h00, 8'h01, 8'hFF};
    if ($urandom_range(0, 7) == 0) return c[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic run16(input logic [15:0] m, input logic [15:0] q,
                       output logic [31:0] p, output int cyc,
                       output int busyc);
    m16 = m;
    q16 = q;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    cyc = 0;
    busyc = busy16 ? 1 : 0;
    while (!ready16 && cyc < 64) begin
      tick();
      cyc++;
      if (busy16) busyc++;
    end
    p = p16;
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int cyc);
    m8 = m;
    q8 = q;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!ready8 && cyc < 64) begin
      tick();
      cyc++;
    end
    p = p8;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (busy16 !== 1'b0 || ready16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags16 busy=%b ready=%b want 0 0",
               busy16, ready16);
    end
    checks++;
    if (p16 !== 32'h0) begin
      errors++;
      $display("FAIL reset_product16 got %h want 0", p16);
    end
    checks++;
    if (busy8 !== 1'b0 || ready8 !== 1'b0 || p8 !== 16'h0) begin
      errors++;
      $display("FAIL reset_w8 busy=%b ready=%b p=%h want 0 0 0",
               busy8, ready8, p8);
    end
  endtask

  task automatic test_basic;
    logic [31:0] p;
    int cyc, busyc;
    run16(16'd3, 16'd5, p, cyc, busyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL basic_latency got %0d want 16", cyc);
    end
    checks++;
    if (busyc !== 16) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 16", busyc);
    end
    checks++;
    if (p !== 32'h0000000F) begin
      errors++;
      $display("FAIL basic_product got %h want 0000000f", p);
    end
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
    checks++;
    if (ready16 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_drop got %b want 0", ready16);
    end
  endtask

  task automatic test_signed;
    logic [15:0] mt [4];
    logic [15:0] qt [4];
    logic [31:0] et [4];
    logic [31:0] p;
    int cyc, busyc;
    mt = '{16'hFFF9, 16'h8000, 16'h7FFF, 16'h0000};
    qt = '{16'h0006, 16'h8000, 16'h8000, 16'h1234};
    et = '{32'hFFFFFFD6, 32'h40000000, 32'hC0008000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run16(mt[i], qt[i], p, cyc, busyc);
      checks++;
      if (p !== et[i] || cyc !== 16) begin
        errors++;
        $display("FAIL signed_%0d got %h in %0d want %h in 16",
                 i, p, cyc, et[i]);
      end
      ack16 = 1'b1;
      tick();
      ack16 = 1'b0;
    end
  endtask

  task automatic test_ignored;
    logic [31:0] hold;
    int cyc;
    m16 = 16'd1234;
    q16 = 16'hFFC9;
    start16 = 1'b1;
    tick();
    cyc = 0;
    while (!ready16 && cyc < 64) begin
      tick();
      cyc++;
      ack16 = (cyc == 4);
    end
    ack16 = 1'b0;
    checks++;
    if (cyc !== 16 || p16 !== ref16(16'd1234, 16'hFFC9)) begin
      errors++;
      $display("FAIL ignored_first got %h in %0d want %h in 16",
               p16, cyc, ref16(16'd1234, 16'hFFC9));
    end
    hold = p16;
    m16 = 16'hF00D;
    q16 = 16'd77;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ready16 !== 1'b1 || busy16 !== 1'b0 || p16 !== hold) begin
        errors++;
        $display("FAIL ignored_hold_%0d ready=%b busy=%b p=%h want 1 0 %h",
                 i, ready16, busy16, p16, hold);
      end
    end
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
    checks++;
    if (ready16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_ack ready=%b busy=%b want 0 0",
               ready16, busy16);
    end
    tick();
    start16 = 1'b0;
    checks++;
    if (busy16 !== 1'b1) begin
      errors++;
      $display("FAIL ignored_restart busy=%b want 1", busy16);
    end
    cyc = 0;
    while (!ready16 && cyc < 64) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 16 || p16 !== ref16(16'hF00D, 16'd77)) begin
      errors++;
      $display("FAIL ignored_second got %h in %0d want %h in 16",
               p16, cyc, ref16(16'hF00D, 16'd77));
    end
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] p;
    int cyc, busyc;
    m16 = 16'd100;
    q16 = 16'd200;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy16 !== 1'b0 || ready16 !== 1'b0 || p16 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid busy=%b ready=%b p=%h want 0 0 0",
               busy16, ready16, p16);
    end
    run16(16'd100, 16'd200, p, cyc, busyc);
    checks++;
    if (p !== 32'h00004E20 || cyc !== 16) begin
      errors++;
      $display("FAIL reset_mid_rerun got %h in %0d want 00004e20 in 16",
               p, cyc);
    end
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa, pb;
    int t, r1, r2, tcn;
    pa = '0;
    pb = '0;
    ack16 = 1'b1;
    start16 = 1'b1;
    m16 = 16'hFFF3;
    q16 = 16'd421;
    tick();
    m16 = 16'd9001;
    q16 = 16'h8001;
    t = 0;
    r1 = -1;
    r2 = -1;
    tcn = 0;
    while (r2 < 0 && t < 80) begin
      tick();
      t++;
      if (dut16.u_counter.tc_o) tcn++;
      if (ready16) begin
        if (r1 < 0) begin
          r1 = t;
          pa = p16;
        end else begin
          r2 = t;
          pb = p16;
          start16 = 1'b0;
        end
      end
    end
    start16 = 1'b0;
    tick();
    ack16 = 1'b0;
    checks++;
    if (r1 !== 16 || r2 - r1 !== 18) begin
      errors++;
      $display("FAIL b2b_spacing first=%0d gap=%0d want 16 18",
               r1, r2 - r1);
    end
    checks++;
    if (pa !== ref16(16'hFFF3, 16'd421)) begin
      errors++;
      $display("FAIL b2b_first got %h want %h",
               pa, ref16(16'hFFF3, 16'd421));
    end
    checks++;
    if (pb !== ref16(16'd9001, 16'h8001)) begin
      errors++;
      $display("FAIL b2b_second got %h want %h",
               pb, ref16(16'd9001, 16'h8001));
    end
    checks++;
    if (tcn !== 2) begin
      errors++;
      $display("FAIL b2b_terminal got %0d want 2", tcn);
    end
    tick();
    checks++;
    if (busy16 !== 1'b0 || ready16 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b ready=%b want 0 0",
               busy16, ready16);
    end
  endtask

  task automatic test_random16(input int n);
    logic [15:0] m, q;
    logic [31:0] p;
    int cyc, busyc;
    for (int i = 0; i < n; i++) begin
      m = pick16();
      q = pick16();
      run16(m, q, p, cyc, busyc);
      checks++;
      if (p !== ref16(m, q) || cyc !== 16) begin
        errors++;
        $display("FAIL rand16 m=%h q=%h got %h in %0d want %h in 16",
                 m, q, p, cyc, ref16(m, q));
      end
      repeat ($urandom_range(0, 2)) tick();
      ack16 = 1'b1;
      tick();
      ack16 = 1'b0;
    end
  endtask

  task automatic test_random8(input int n);
    logic [7:0] m, q;
    logic [15:0] p;
    int cyc;
    for (int i = 0; i < n; i++) begin
      m = pick8();
      q = pick8();
      run8(m, q, p, cyc);
      checks++;
      if (p !== ref8(m, q) || cyc !== 8) begin
        errors++;
        $display("FAIL rand8 m=%h q=%h got %h in %0d want %h in 8",
                 m, q, p, cyc, ref8(m, q));
      end
      repeat ($urandom_range(0, 2)) tick();
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start16 = 1'b0;
    ack16   = 1'b0;
    m16     = '0;
    q16     = '0;
    start8  = 1'b0;
    ack8    = 1'b0;
    m8      = '0;
    q8      = '0;
    test_reset();
    test_basic();
    test_signed();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random16(800);
    test_random8(1200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
